// File: rtl/bitrev_pkg.sv
// Accelerator register map and stream-manager FSM states.
package bitrev_pkg;

  localparam logic [31:0] AccInputOfs  = 32'h0000_0000;
  localparam logic [31:0] AccOutputOfs = 32'h0000_0004;
  localparam logic [31:0] AccStatusOfs = 32'h0000_0008;

  localparam logic [3:0]  ObiFullBe    = 4'hF;

  typedef enum logic [3:0] {
    IDLE,
    SRC_RD,
    SRC_R,
    IN_WR,
    POLL_RD,
    POLL_R,
    OUT_RD,
    OUT_R,
    DST_WR,
    DST_R,
    DONE
  } bsm_state_e;

  // Byte address of 32-bit word idx in a buffer; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/croc_pkg.sv
// OBI configuration and manager-port types shared across the SoC slice.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

endpackage

package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/bitrev_stream_manager.sv
// Streams a source buffer through the bit-reversal accelerator into a
// destination buffer using a single OBI manager port, one transaction at a time.
module bitrev_stream_manager
  import bitrev_pkg::*;
  import croc_pkg::*;
#(
  parameter obi_pkg::obi_cfg_t ObiCfg  = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       K       = 10,
  parameter int unsigned       PollMax = 4096
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [31:0]  src_addr_i,
  input  logic [31:0]  dst_addr_i,
  input  logic [31:0]  acc_base_i,
  input  logic [K:0]   count_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output mgr_obi_req_t obi_req_o,
  input  mgr_obi_rsp_t obi_rsp_i
);

  localparam int unsigned PollW = $clog2(PollMax + 1);

  bsm_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      data_q, data_d;
  logic [K:0]       cnt_q, cnt_d;
  logic [K:0]       idx_q, idx_d;
  logic [K:0]       idx_inc;
  logic [PollW-1:0] poll_q, poll_d;
  logic             err_q, err_d;
  logic             last_word;

  // Response ID/optional fields and the ID width are not consumed: aid is fixed at 0.
  logic unused_sig;
  assign unused_sig = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional, ObiCfg.IdWidth};

  assign idx_inc   = idx_q + (K+1)'(1);
  assign last_word = (idx_inc == cnt_q);
  assign err_o     = err_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
    end
  end

  // Next-state, OBI request and status outputs; requests depend only on registers.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    acc_d     = acc_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    err_d     = err_q;
    obi_req_o = '0;
    busy_o    = (state_q != IDLE);
    done_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          acc_d   = acc_base_i;
          cnt_d   = count_i;
          idx_d   = '0;
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = (count_i == '0) ? DONE : SRC_RD;
        end
      end

      SRC_RD: begin
        obi_req_o.req    = 1'b1;
        obi_req_o.a.addr = word_addr(src_q, 32'(idx_q));
        obi_req_o.a.be   = ObiFullBe;
        if (obi_rsp_i.gnt) state_d = SRC_R;
      end

      SRC_R: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = obi_rsp_i.r.rdata;
            state_d = IN_WR;
          end
        end
      end

      // INPUT writes are posted: the word is considered delivered at grant.
      IN_WR: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.addr  = acc_q + AccInputOfs;
        obi_req_o.a.we    = 1'b1;
        obi_req_o.a.be    = ObiFullBe;
        obi_req_o.a.wdata = data_q;
        if (obi_rsp_i.gnt) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = POLL_RD;
          end else begin
            idx_d   = idx_inc;
            state_d = SRC_RD;
          end
        end
      end

      POLL_RD: begin
        obi_req_o.req    = 1'b1;
        obi_req_o.a.addr = acc_q + AccStatusOfs;
        obi_req_o.a.be   = ObiFullBe;
        if (obi_rsp_i.gnt) state_d = POLL_R;
      end

      // The poll budget is per output word; the last permitted poll failing ends the job.
      POLL_R: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (obi_rsp_i.r.rdata[0]) begin
            poll_d  = '0;
            state_d = OUT_RD;
          end else if (poll_q == PollW'(PollMax - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            poll_d  = poll_q + PollW'(1);
            state_d = POLL_RD;
          end
        end
      end

      OUT_RD: begin
        obi_req_o.req    = 1'b1;
        obi_req_o.a.addr = acc_q + AccOutputOfs;
        obi_req_o.a.be   = ObiFullBe;
        if (obi_rsp_i.gnt) state_d = OUT_R;
      end

      OUT_R: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = obi_rsp_i.r.rdata;
            state_d = DST_WR;
          end
        end
      end

      DST_WR: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.addr  = word_addr(dst_q, 32'(idx_q));
        obi_req_o.a.we    = 1'b1;
        obi_req_o.a.be    = ObiFullBe;
        obi_req_o.a.wdata = data_q;
        if (obi_rsp_i.gnt) state_d = DST_R;
      end

      DST_R: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            state_d = POLL_RD;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitrev_stream_manager.sv
// Scoreboard bench: expected OBI transactions are queued per job and checked by
// the bus responder; a memory plus bit-reversal accelerator model answers requests.
module tb_bitrev_stream_manager;
  import croc_pkg::*;

  localparam int unsigned K       = 2;
  localparam int unsigned N       = 4;
  localparam int unsigned PollMax = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  src, dst, acc;
  logic [K:0]   count;
  logic         busy, done, err;
  mgr_obi_req_t req;
  mgr_obi_rsp_t rsp;

  always #5 clk = ~clk;

  bitrev_stream_manager #(.K(K), .PollMax(PollMax)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .acc_base_i (acc),
    .count_i    (count),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .obi_req_o  (req),
    .obi_rsp_i  (rsp)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic        status_q[$];
  logic [31:0] acc_in[$];
  logic [31:0] mem [logic [31:0]];

  int total = 0;
  int bad   = 0;
  int done_cnt, grant_idx, err_at, wait_n;
  int status_reads, out_reads, in_writes, dst_writes;
  int unsigned out_idx;
  bit stall5, active, pend, pend_err;
  logic [31:0] pend_rdata;
  mgr_obi_a_chan_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int unsigned rev(input int unsigned j);
    int unsigned r = 0;
    for (int unsigned b = 0; b < K; b++)
      if (((j >> b) & 1) != 0) r = r | (1 << (K - 1 - b));
    return r;
  endfunction

  function automatic void push_t(input logic [31:0] a, input logic we, input logic [31:0] wd);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd;
    exp_q.push_back(t);
  endfunction

  // Accelerator: a full frame comes back in bit-reversed order, partial frames in order.
  function automatic logic [31:0] acc_output();
    int unsigned i;
    logic [31:0] v;
    i = (acc_in.size() == N) ? rev(out_idx) : out_idx;
    v = (i < acc_in.size()) ? acc_in[i] : 32'h0;
    out_idx++;
    return v;
  endfunction

  task automatic grant(input mgr_obi_a_chan_t a);
    txn_t e;
    bit   is_err;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_req: got addr=%h we=%0d, expected no request", a.addr, a.we);
    end else begin
      e = exp_q.pop_front();
      chk("req_addr", a.addr, e.addr);
      chk("req_we", 32'(a.we), 32'(e.we));
      if (e.we) chk("req_wdata", a.wdata, e.wdata);
      chk("req_be", 32'(a.be), 32'hF);
      chk("req_aid", 32'(a.aid), 32'h0);
      chk("req_aopt", 32'(a.a_optional), 32'h0);
    end
    is_err = (grant_idx == err_at);
    grant_idx++;
    if (a.we && a.addr == acc) begin
      acc_in.push_back(a.wdata);
      in_writes++;
    end else begin
      pend = 1'b1; pend_err = is_err; pend_rdata = 32'h0;
      if (!a.we) begin
        if (a.addr == acc + 32'h8) begin
          status_reads++;
          if (status_q.size() > 0) pend_rdata = 32'(status_q.pop_front());
        end else if (a.addr == acc + 32'h4) begin
          out_reads++;
          pend_rdata = acc_output();
        end else begin
          pend_rdata = mem.exists(a.addr) ? mem[a.addr] : 32'h0;
        end
      end else begin
        mem[a.addr] = a.wdata;
        dst_writes++;
      end
    end
  endtask

  // Bus responder / monitor: drives gnt and rvalid on the falling edge.
  initial begin
    rsp = '0; active = 0; pend = 0; pend_err = 0; pend_rdata = '0; wait_n = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      rsp.gnt = 1'b0; rsp.rvalid = 1'b0; rsp.r = '0;
      if (pend) begin
        rsp.rvalid = 1'b1; rsp.r.rdata = pend_rdata; rsp.r.err = pend_err; pend = 0;
      end
      if (!rst_n) begin
        active = 0;
      end else if (req.req) begin
        if (!active) begin
          active = 1; held = req.a;
          if (stall5 && req.a.we && req.a.addr == acc) begin
            wait_n = 5; stall5 = 0;
          end else begin
            wait_n = $urandom_range(0, 2);
          end
        end else begin
          chk("stall_addr", req.a.addr, held.addr);
          chk("stall_wdata", req.a.wdata, held.wdata);
          chk("stall_we", 32'(req.a.we), 32'(held.we));
        end
        if (wait_n == 0) begin
          rsp.gnt = 1'b1; active = 0;
          grant(req.a);
        end else begin
          wait_n--;
        end
      end else if (active) begin
        chk("req_held_until_gnt", 32'(req.req), 32'h1);
        active = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // err_mode: -1 none, -2 random response-bearing transaction, >=0 fixed grant index.
  task automatic run_job(input int c, input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] a, input int err_mode, input bit stuck,
                         input bit st5, input bit seq, input bit rst_in_dst);
    logic [31:0] sw[$];
    logic [31:0] exp_out[$];
    int          cand[$];
    int          eidx, np, k;
    bit          exp_err;
    txn_t        tmp;

    exp_q.delete(); status_q.delete(); acc_in.delete();
    for (int i = 0; i < c; i++) begin
      sw.push_back(seq ? 32'(i + 1) : $urandom);
      mem[s + 32'(i) * 4] = sw[i];
    end
    for (int j = 0; j < c; j++)
      exp_out.push_back((c == N) ? sw[rev(j)] : sw[j]);

    for (int i = 0; i < c; i++) begin
      cand.push_back(exp_q.size());
      push_t(s + 32'(i) * 4, 1'b0, 32'h0);
      push_t(a, 1'b1, sw[i]);
    end
    for (int j = 0; j < c; j++) begin
      np = stuck ? PollMax : $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        cand.push_back(exp_q.size());
        push_t(a + 32'h8, 1'b0, 32'h0);
        status_q.push_back(1'b0);
      end
      if (stuck) break;
      cand.push_back(exp_q.size());
      push_t(a + 32'h8, 1'b0, 32'h0);
      status_q.push_back(1'b1);
      cand.push_back(exp_q.size());
      push_t(a + 32'h4, 1'b0, 32'h0);
      cand.push_back(exp_q.size());
      push_t(d + 32'(j) * 4, 1'b1, exp_out[j]);
    end

    eidx = err_mode;
    if (err_mode == -2) eidx = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : -1;
    if (eidx >= 0) while (exp_q.size() > eidx + 1) tmp = exp_q.pop_back();
    exp_err = stuck || (eidx >= 0);

    grant_idx = 0; err_at = eidx; stall5 = st5; out_idx = 0; done_cnt = 0;
    status_reads = 0; out_reads = 0; in_writes = 0; dst_writes = 0;

    src = s; dst = d; acc = a; count = (K+1)'(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr_on_start", 32'(err), 32'h0);
    chk("busy_after_start", 32'(busy), 32'h1);
    if (c == 0) chk("done_latency_1", 32'(done), 32'h1);

    if (rst_in_dst) begin
      k = 0;
      while (dst_writes < 1 && k < 3000) begin @(posedge clk); #1; k++; end
      chk("reached_dst_r", 32'(dst_writes), 32'h1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_req", 32'(req.req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      exp_q.delete(); status_q.delete(); pend = 0;
      @(posedge clk); #1;
      chk("post_rst_req", 32'(req.req), 32'h0);
      return;
    end

    k = 0;
    while (!done && k < 3000) begin @(posedge clk); #1; k++; end
    chk("done_seen", 32'(done), 32'h1);
    chk("err_at_done", 32'(err), 32'(exp_err));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'h0);
    chk("idle_after_done", 32'(busy), 32'h0);
    chk("err_sticky", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk("start_in_done_ignored", 32'(busy), 32'h0);
    chk("done_pulses", 32'(done_cnt), 32'h1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    if (!exp_err)
      for (int j = 0; j < c; j++) chk("dst_word", mem[d + 32'(j) * 4], exp_out[j]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; acc = '0; count = '0;
    done_cnt = 0; grant_idx = 0; err_at = -1; stall5 = 0; out_idx = 0;
    status_reads = 0; out_reads = 0; in_writes = 0; dst_writes = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req", 32'(req.req), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frame {1,2,3,4} must land as {1,3,2,4}.
    run_job(4, 32'h1000, 32'h2000, 32'h8000_0000, -1, 0, 0, 1, 0);
    chk("bitrev_dst0", mem[32'h2000], 32'd1);
    chk("bitrev_dst1", mem[32'h2004], 32'd3);
    chk("bitrev_dst2", mem[32'h2008], 32'd2);
    chk("bitrev_dst3", mem[32'h200C], 32'd4);

    // Empty job.
    run_job(0, 32'h1000, 32'h2000, 32'h8000_0000, -1, 0, 0, 0, 0);

    // Grant withheld 5 cycles on an INPUT write.
    run_job(4, 32'h1100, 32'h2100, 32'h8000_0000, -1, 0, 1, 0, 0);
    chk("input_writes", 32'(in_writes), 32'd4);

    // STATUS stuck at 0.
    run_job(4, 32'h1200, 32'h2200, 32'h8000_0000, -1, 1, 0, 0, 0);
    chk("stuck_status_reads", 32'(status_reads), 32'd8);
    chk("stuck_output_reads", 32'(out_reads), 32'd0);

    // Bus error on the third source read (grant index 4), then a clean job clears err_o.
    run_job(4, 32'h1300, 32'h2300, 32'h8000_0000, 4, 0, 0, 0, 0);
    chk("err_in_writes", 32'(in_writes), 32'd2);
    run_job(3, 32'h1400, 32'h2400, 32'h8000_0000, -1, 0, 0, 0, 0);

    // Reset while waiting for a destination write response, then a full job.
    run_job(4, 32'h1000, 32'h2000, 32'h8000_0000, -1, 0, 0, 0, 1);
    run_job(4, 32'h1000, 32'h2000, 32'h8000_0000, -1, 0, 0, 1, 0);
    chk("rerun_dst1", mem[32'h2004], 32'd3);
    chk("rerun_dst2", mem[32'h2008], 32'd2);

    // Source buffer straddling the top of the address space.
    run_job(4, 32'hFFFF_FFF8, 32'h4000_0000, 32'h8000_0100, -1, 0, 0, 0, 0);

    // Randomized jobs, some with an injected bus error.
    for (int n = 0; n < 14; n++) begin
      logic [31:0] rs, rd, ra;
      rs = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'h1000_0000 + 32'($urandom_range(0, 255)) * 4;
      rd = 32'h4000_0000 + 32'($urandom_range(0, 255)) * 4;
      ra = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 16;
      run_job($urandom_range(0, 4), rs, rd, ra, ($urandom_range(0, 3) == 0) ? -2 : -1, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitrev_stream_manager.md
BITREV_STREAM_MANAGER -- requirements
Module: bitrev_stream_manager

Interface
REQ-001 Parameter ObiCfg, default obi_pkg::ObiDefaultConfig, OBI manager port configuration.
REQ-002 Parameter K, default 10, log2 of the accelerator frame length.
REQ-003 Parameter PollMax, default 4096, maximum STATUS polls per output word before timeout.
REQ-004 Port clk_i  in  1  single clock; all state on rising edge.
REQ-005 Port rst_ni  in  1  reset, synchronous and active-low.
REQ-006 Port start_i  in  1  one-cycle job start; ignored while busy_o=1.
REQ-007 Port src_addr_i  in  32  word-aligned source buffer base, sampled at start.
REQ-008 Port dst_addr_i  in  32  word-aligned destination buffer base, sampled at start.
REQ-009 Port acc_base_i  in  32  accelerator base: INPUT +0x0, OUTPUT +0x4, STATUS +0x8; sampled at start.
REQ-010 Port count_i  in  K+1  words per job, 0..2^K, sampled at start.
REQ-011 Port busy_o  out  1  job in progress.
REQ-012 Port done_o  out  1  one-cycle pulse at job end, success or error.
REQ-013 Port err_o  out  1  sticky error of the last job; cleared by the next accepted start.
REQ-014 Port obi_req_o  out  mgr_obi_req_t  OBI manager request.
REQ-015 Port obi_rsp_i  in  mgr_obi_rsp_t  OBI manager response.

Function
REQ-016 Exactly one OBI transaction outstanding at a time; req held with a/wdata stable until gnt.
REQ-017 FSM states: IDLE, SRC_RD, SRC_R, IN_WR, POLL_RD, POLL_R, OUT_RD, OUT_R, DST_WR, DST_R, DONE.
REQ-018 IDLE + start_i: latch inputs, clear err_o, word index i=0; count=0 -> DONE, else SRC_RD.
REQ-019 Fill phase: SRC_RD reads src+4i; SRC_R captures rdata on rvalid; IN_WR writes it to acc_base+0x0 (we=1, be=4'hF).
REQ-020 INPUT writes are posted and complete at gnt; no rvalid is awaited; then i+1; i=count -> POLL_RD with i=0, else SRC_RD.
REQ-021 Drain phase: POLL_RD reads acc_base+0x8; in POLL_R, rdata[0]=1 -> OUT_RD, else increment poll counter and return to POLL_RD.
REQ-022 OUT_RD reads acc_base+0x4; OUT_R captures rdata; DST_WR writes it to dst+4i; DST_R waits rvalid; then i+1; i=count -> DONE, else POLL_RD.
REQ-023 The poll counter resets to 0 on each entry to OUT_RD; reaching PollMax without rdata[0]=1 sets err_o and goes to DONE.
REQ-024 rvalid with err=1 in any *_R state: set err_o, go to DONE, issue no further requests.
REQ-025 DONE: done_o=1 for exactly one cycle, busy_o=0 from the next cycle, return to IDLE.
REQ-026 busy_o=1 in every state except IDLE.
REQ-027 Address arithmetic is 32-bit modulo 2^32; base+4i wraps silently.
REQ-028 aid is constant 0; rid is ignored; r_optional and a_optional are driven 0.
REQ-029 start_i asserted in the same cycle as done_o is ignored.

Reset
REQ-030 On rst_ni=0 at a clock edge: state IDLE, obi_req_o.req=0, busy_o=0, done_o=0, err_o=0, all counters and address registers 0.
REQ-031 Reset mid-job abandons the job immediately; no request is issued in the cycle after reset.

Structure
REQ-032 Accelerator register offsets (0x0/0x4/0x8) and the FSM state enum live in a shared bitrev_pkg.
REQ-033 Single module; no sub-modules; OBI request/response types come from croc_pkg.

Verification
REQ-034 count=4, src=0x1000 holding {1,2,3,4}, bitrev model K=2 -> dst 0x2000 = {1,3,2,4}, done_o pulses once, err_o=0.
REQ-035 count=0 -> done_o pulses 1 cycle after start, no OBI request, err_o=0.
REQ-036 gnt withheld 5 cycles on an IN_WR -> req/addr/wdata stable throughout, exactly one INPUT write per word.
REQ-037 STATUS stuck at 0, PollMax=8 -> exactly 8 STATUS reads, then err_o=1 and done_o pulse, no OUTPUT read.
REQ-038 err=1 on the 3rd source read -> err_o=1, done_o pulse, no further requests; next start clears err_o.
REQ-039 rst_ni=0 for 1 cycle during DST_R -> req=0, busy_o=0; a new job with count=4 then completes correctly.
